// File: rtl/rgb_pixel_feeder.sv
// rgb_pixel_feeder: buffers packed 24-bit RGB pixels in a small FIFO and
// hands them one at a time to the multi-cycle RGB-to-HSV converter.
// The next pixel is issued only after the converter's Ready rises again,
// so the channels never change in the middle of a conversion.
// Optional build macro: FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that
// drops a stalled pixel and raises the sticky err flag.
module rgb_pixel_feeder #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic [23:0]   pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          conv_ready,
    output logic [31:0]   R,
    output logic [31:0]   G,
    output logic [31:0]   B,
    output logic          Start,
    output logic          px_done,
    output logic [15:0]   pix_count,
    output logic [AW:0]   fifo_level,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;

    logic          push;
    logic          pop;
    logic          done_evt;
    logic          conv_prev;
    logic          conv_rise;
    logic          timeout_hit;

    assign pix_ready  = (level != (AW+1)'(DEPTH));
    assign push       = pix_valid && pix_ready;
    assign conv_rise  = conv_ready && !conv_prev;
    assign fifo_level = level;

    // FIFO storage; no reset needed, occupancy is tracked by level
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= pix_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state, pop request and completion event
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        done_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (conv_rise) begin
                    done_evt   = 1'b1;
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered converter interface: channels, Start/px_done pulses, count
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            R         <= '0;
            G         <= '0;
            B         <= '0;
            Start     <= 1'b0;
            px_done   <= 1'b0;
            pix_count <= '0;
            conv_prev <= 1'b0;
        end else begin
            conv_prev <= conv_ready;
            Start     <= pop;
            px_done   <= done_evt;
            if (done_evt) begin
                pix_count <= pix_count + 16'd1;
            end
            if (pop) begin
                R <= {24'b0, mem[rd_ptr][23:16]};
                G <= {24'b0, mem[rd_ptr][15:8]};
                B <= {24'b0, mem[rd_ptr][7:0]};
            end
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Counts WAIT cycles; the last allowed cycle is TIMEOUT-1
    assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));

    // Watchdog counter and sticky error flag
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit && !conv_rise) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    // Without the watchdog WAIT never expires; TIMEOUT stays referenced only
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

endmodule
